// File: rtl/add_display_pkg.sv
// Shared constants for the signed-sum display: active-low glyphs (gfedcba) and digit enables.
package add_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] AN_OFF  = 2'b11;
   localparam logic [1:0] AN_MAG  = 2'b10;
   localparam logic [1:0] AN_SIGN = 2'b01;

   // 4-bit magnitude; -8 maps to 4'b1000 with no overflow.
   function automatic logic [3:0] abs4(input logic [3:0] v);
      return v[3] ? (~v + 4'd1) : v;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Maps a magnitude 0..8 to an active-low seven-segment glyph; other codes blank the digit.
module seg7_decoder
   import add_display_pkg::*;
(
   input  logic [3:0] mag,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = SEG_BLANK;
      case (mag)
         4'd0: glyph = SEG_0;
         4'd1: glyph = SEG_1;
         4'd2: glyph = SEG_2;
         4'd3: glyph = SEG_3;
         4'd4: glyph = SEG_4;
         4'd5: glyph = SEG_5;
         4'd6: glyph = SEG_6;
         4'd7: glyph = SEG_7;
         4'd8: glyph = SEG_8;
         default: glyph = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/add_result_display.sv
// Holds the adder's signed sum and drives a two-digit multiplexed display (sign + magnitude).
module add_result_display
   import add_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       C_in,
   input  logic             load,
   input  logic             clr,
   output logic [3:0]       C_held,
   output logic             valid,
   output logic [6:0]       seg,
   output logic [1:0]       an
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [3:0]       c_held_q, c_held_d;
   logic             valid_q,  valid_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             sel_q,    sel_d;
   logic [6:0]       seg_q,    seg_d;
   logic [1:0]       an_q,     an_d;
   logic [6:0]       mag_glyph;

   seg7_decoder u_dec (
      .mag   (abs4(c_held_q)),
      .glyph (mag_glyph)
   );

   always_comb begin
      c_held_d = c_held_q;
      valid_d  = valid_q;
      if (load) begin
         c_held_d = C_in;
         valid_d  = 1'b1;
      end else if (clr) begin
         valid_d  = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      sel_d = sel_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         sel_d = ~sel_q;
      end
   end

   // Outputs are built from the registered state, so they trail it by one edge.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      if (valid_q) begin
         if (!sel_q) begin
            an_d  = AN_MAG;
            seg_d = mag_glyph;
         end else begin
            an_d  = AN_SIGN;
            seg_d = c_held_q[3] ? SEG_MINUS : SEG_BLANK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_held_q <= '0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         seg_q    <= SEG_BLANK;
         an_q     <= AN_OFF;
      end else begin
         c_held_q <= c_held_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign C_held = c_held_q;
   assign valid  = valid_q;
   assign seg    = seg_q;
   assign an     = an_q;

endmodule

// File: tb/tb_add_result_display.sv
// Randomized and directed checks of add_result_display against a cycle-level reference model.
module tb_add_result_display;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] C_in = 4'd0;
   logic       load = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] C_held;
   logic       valid;
   logic [6:0] seg;
   logic [1:0] an;

   int n_tests = 0;
   int n_fail  = 0;

   add_result_display #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .C_in   (C_in),
      .load   (load),
      .clr    (clr),
      .C_held (C_held),
      .valid  (valid),
      .seg    (seg),
      .an     (an)
   );

   always #5 clk = ~clk;

   // Reference model: sel is derived from the number of edges since reset.
   logic [6:0] glyph [0:8];
   int         m_held = 0;
   bit         m_valid = 1'b0;
   int         m_cyc = 0;
   logic [6:0] e_seg = 7'b1111111;
   logic [1:0] e_an = 2'b11;

   initial begin
      glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
      glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
      glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
   end

   always @(posedge clk) begin
      int mag;
      int msel;
      if (rst) begin
         m_held = 0; m_valid = 1'b0; m_cyc = 0;
         e_seg = 7'b1111111; e_an = 2'b11;
      end else begin
         msel = (m_cyc / DIV) % 2;
         mag  = (m_held < 0) ? -m_held : m_held;
         if (!m_valid) begin
            e_an = 2'b11; e_seg = 7'b1111111;
         end else if (msel == 0) begin
            e_an = 2'b10; e_seg = glyph[mag];
         end else begin
            e_an = 2'b01; e_seg = (m_held < 0) ? 7'b0111111 : 7'b1111111;
         end
         if (load) begin
            m_held = int'($signed(C_in)); m_valid = 1'b1;
         end else if (clr) begin
            m_valid = 1'b0;
         end
         m_cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; clr = 1'b1; C_in = 4'b0111;
      step(); step();
      n_tests++;
      if ({C_held, valid, an, seg} !== {4'd0, 1'b0, 2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL reset: got held=%b valid=%b an=%b seg=%b, want 0000 0 11 1111111",
                  C_held, valid, an, seg);
      end
      rst = 1'b0; load = 1'b0; clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_tests++;
         if ({valid, an, seg} !== {1'b0, 2'b11, 7'b1111111}) begin
            n_fail++;
            $display("FAIL idle_blank cyc%0d: got valid=%b an=%b seg=%b, want 0 11 1111111",
                     i, valid, an, seg);
         end
      end
   endtask

   // Loads one value, then runs two full display periods checking model and fixed glyphs.
   task automatic test_value(input logic [3:0] v, input logic [6:0] mag_g, input logic [6:0] sign_g,
                             input string nm);
      C_in = v; load = 1'b1;
      step();
      load = 1'b0;
      n_tests++;
      if ({C_held, valid} !== {v, 1'b1}) begin
         n_fail++;
         $display("FAIL %s capture: got held=%b valid=%b, want %b 1", nm, C_held, valid, v);
      end
      for (int i = 0; i < 2 * DIV + 1; i++) begin
         step();
         n_tests++;
         if ({C_held, valid, an, seg} !== {4'(m_held), m_valid, e_an, e_seg}) begin
            n_fail++;
            $display("FAIL %s model cyc%0d: got %b %b %b %b, want %b %b %b %b", nm, i,
                     C_held, valid, an, seg, 4'(m_held), m_valid, e_an, e_seg);
         end
         if (an == 2'b10) begin
            n_tests++;
            if (seg !== mag_g) begin
               n_fail++;
               $display("FAIL %s mag_glyph: got %b, want %b", nm, seg, mag_g);
            end
         end else if (an == 2'b01) begin
            n_tests++;
            if (seg !== sign_g) begin
               n_fail++;
               $display("FAIL %s sign_glyph: got %b, want %b", nm, seg, sign_g);
            end
         end
      end
   endtask

   task automatic test_sweep();
      for (int c = 0; c < 16; c++) begin
         C_in = 4'(c); load = 1'b1;
         step();
         load = 1'b0;
         for (int i = 0; i < 2 * DIV; i++) begin
            step();
            n_tests++;
            if ({C_held, valid, an, seg} !== {4'(m_held), m_valid, e_an, e_seg}) begin
               n_fail++;
               $display("FAIL sweep code%0d cyc%0d: got %b %b %b %b, want %b %b %b %b", c, i,
                        C_held, valid, an, seg, 4'(m_held), m_valid, e_an, e_seg);
            end
         end
      end
   endtask

   task automatic test_clr_load();
      C_in = 4'b0011; load = 1'b1; clr = 1'b1;
      step();
      load = 1'b0; clr = 1'b0;
      n_tests++;
      if (valid !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_load valid: got %b, want 1", valid);
      end
      for (int i = 0; i < 2 * DIV; i++) begin
         step();
         if (an == 2'b10) begin
            n_tests++;
            if (seg !== 7'b0110000) begin
               n_fail++;
               $display("FAIL clr_load digit3: got %b, want 0110000", seg);
            end
         end
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      n_tests++;
      if ({C_held, valid, an, seg} !== {4'b0011, 1'b0, 2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL clr_only: got %b %b %b %b, want 0011 0 11 1111111", C_held, valid, an, seg);
      end
      // Counter must have kept running through the blank period.
      repeat (3) step();
      C_in = 4'b1110; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 2 * DIV; i++) begin
         step();
         n_tests++;
         if ({C_held, valid, an, seg} !== {4'(m_held), m_valid, e_an, e_seg}) begin
            n_fail++;
            $display("FAIL clr_phase cyc%0d: got %b %b %b %b, want %b %b %b %b", i,
                     C_held, valid, an, seg, 4'(m_held), m_valid, e_an, e_seg);
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      C_in = 4'b1010; load = 1'b1;
      step();
      load = 1'b0;
      guard = 0;
      while (m_cyc % DIV != 2 && guard < 10) begin
         step();
         guard++;
      end
      n_tests++;
      if (guard >= 10) begin
         n_fail++;
         $display("FAIL reset_mid align: got no counter=2 within %0d cycles, want alignment", guard);
      end
      rst = 1'b1;
      step();
      n_tests++;
      if ({C_held, valid, an, seg} !== {4'd0, 1'b0, 2'b11, 7'b1111111}) begin
         n_fail++;
         $display("FAIL reset_mid: got %b %b %b %b, want 0000 0 11 1111111", C_held, valid, an, seg);
      end
      rst = 1'b0; C_in = 4'b0101; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         step();
         n_tests++;
         if (an !== ((i < 5) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL reset_mid switch edge r+%0d: got an=%b, want %b", i, an,
                     (i < 5) ? 2'b10 : 2'b01);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         C_in = 4'($urandom_range(0, 15));
         load = ($urandom_range(0, 3) == 0);
         clr  = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 59) == 0);
         step();
         n_tests++;
         if ({C_held, valid, an, seg} !== {4'(m_held), m_valid, e_an, e_seg}) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %b %b %b %b, want %b %b %b %b", i,
                     C_held, valid, an, seg, 4'(m_held), m_valid, e_an, e_seg);
         end
      end
      rst = 1'b0; load = 1'b0; clr = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_value(4'b1101, 7'b0110000, 7'b0111111, "minus3");
      test_value(4'b0110, 7'b0000010, 7'b1111111, "plus6");
      test_value(4'b1000, 7'b0000000, 7'b0111111, "minus8");
      test_value(4'b1000, 7'b0000000, 7'b0111111, "minus8_repeat");
      test_sweep();
      test_clr_load();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
